lsu_mem_stage: RTL and testbench

- Load/store unit directly downstream of the ALU in the execute/memory boundary.
- Consumes the ALU result as the effective address and the rs2 read value as store data.
- Drives a simple request/grant/response data-memory bus, stalls the pipeline while an access is outstanding, and returns aligned, extended load data for writeback.
- Handles one access at a time. Detects misaligned, illegal and timed-out accesses.

---
 rtl/riscv_pkg.sv | 46 ++++
 rtl/lsu_load_align.sv | 23 ++
 rtl/lsu_mem_stage.sv | 140 ++++++++++++++
 tb/tb_lsu_mem_stage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I memory-access definitions: funct3 encodings, LSU state type and access helpers.
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

    function automatic logic lsu_access_legal(logic rd, logic wr, logic [2:0] f3, logic [1:0] off);
        logic f3_ok;
        logic align_ok;
        if (rd) f3_ok = f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
        else    f3_ok = f3 inside {F3_SB, F3_SH, F3_SW};
        case (f3[1:0])
            2'b00:   align_ok = 1'b1;
            2'b01:   align_ok = ~off[0];
            2'b10:   align_ok = (off == 2'b00);
            default: align_ok = 1'b0;
        endcase
        return f3_ok & align_ok & ~(rd & wr);
    endfunction

    function automatic logic [3:0] lsu_byte_en(logic [2:0] f3, logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate store data across every lane so the byte enables alone select the target.
    function automatic logic [31:0] lsu_store_data(logic [2:0] f3, logic [31:0] w);
        case (f3[1:0])
            2'b00:   return {4{w[7:0]}};
            2'b01:   return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Shifts a bus read word down to the accessed lane and sign/zero-extends it per funct3.
module lsu_load_align (
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);
    import riscv_pkg::*;

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {addr_lo, 3'b000};
        case (funct3)
            F3_LB:   result = {{24{shifted[7]}}, shifted[7:0]};
            F3_LBU:  result = {24'b0, shifted[7:0]};
            F3_LH:   result = {{16{shifted[15]}}, shifted[15:0]};
            F3_LHU:  result = {16'b0, shifted[15:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store unit at the execute/memory boundary: one access at a time on a req/gnt/rvalid bus,
// with misalignment, illegal-op and timeout detection.
module lsu_mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        lsu_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);
    import riscv_pkg::*;

    localparam int unsigned     CntW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    lsu_state_t      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     load_data_q, load_data_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [3:0]      be_q, be_d;
    logic            mem_op;
    logic [31:0]     aligned;

    lsu_load_align u_align (
        .rdata   (bus_rdata),
        .addr_lo (addr_q[1:0]),
        .funct3  (funct3_q),
        .result  (aligned)
    );

    assign mem_op = ex_valid & (mem_read | mem_write);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        load_data_d = load_data_q;
        funct3_d    = funct3_q;
        be_d        = be_q;
        unique case (state_q)
            IDLE: begin
                if (mem_op) begin
                    if (!lsu_access_legal(mem_read, mem_write, funct3, addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d    = 1'b0;
                        cnt_d    = '0;
                        we_d     = mem_write;
                        addr_d   = addr;
                        funct3_d = funct3;
                        be_d     = lsu_byte_en(funct3, addr[1:0]);
                        wdata_d  = lsu_store_data(funct3, wdata);
                        state_d  = REQ;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + CntW'(1);
                // A grant in the final allowed cycle still completes the access.
                if (bus_gnt) begin
                    state_d = we_q ? DONE : WAIT;
                end else if (cnt_q == CntLast) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CntW'(1);
                if (bus_rvalid) begin
                    load_data_d = aligned;
                    state_d     = DONE;
                end else if (cnt_q == CntLast) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            load_data_q <= '0;
            funct3_q    <= '0;
            be_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            load_data_q <= load_data_d;
            funct3_q    <= funct3_d;
            be_q        <= be_d;
        end
    end

    assign stall     = ((state_q == IDLE) & mem_op) | (state_q == REQ) | (state_q == WAIT);
    assign done      = (state_q == DONE);
    assign lsu_err   = (state_q == DONE) & err_q;
    assign load_data = load_data_q;
    assign bus_req   = (state_q == REQ);
    assign bus_we    = we_q;
    assign bus_addr  = {addr_q[31:2], 2'b00};
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Randomised and directed bench for lsu_mem_stage against a behavioural access model.
module tb_lsu_mem_stage;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, done, lsu_err;
    logic [31:0] load_data;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_ld   = '0;

    lsu_mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .done       (done),
        .load_data  (load_data),
        .lsu_err    (lsu_err),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_legal(bit rd, bit wr, logic [2:0] f3, logic [31:0] a);
        int unsigned size;
        if (rd && wr) return 0;
        if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 0;
        if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) return 0;
        size = 1 << f3[1:0];
        return (a % size) == 0;
    endfunction

    function automatic logic [3:0] ref_be(logic [2:0] f3, logic [31:0] a);
        int unsigned size = 1 << f3[1:0];
        int unsigned m    = ((1 << size) - 1) << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] ref_wdata(logic [2:0] f3, logic [31:0] w);
        int unsigned size = 1 << f3[1:0];
        if (size == 1) return (w & 32'hff) * 32'h0101_0101;
        if (size == 2) return (w & 32'hffff) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] ref_load(logic [2:0] f3, logic [31:0] a, logic [31:0] rd);
        int unsigned size = 1 << f3[1:0];
        int unsigned v    = rd >> (8 * (a % 4));
        bit          sgn  = (f3 < 3'd4);
        if (size == 1) begin
            v = v % 256;
            if (sgn && v >= 128) v = v - 256;
        end else if (size == 2) begin
            v = v % 65536;
            if (sgn && v >= 32768) v = v - 65536;
        end
        return v;
    endfunction

    // Drive one access and act as the memory: gnt after g REQ cycles, rvalid after r WAIT cycles.
    task automatic run_op(input string tag, input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input int g, input int r,
                          input logic [31:0] rdat);
        bit legal, ok, granted, seen;
        int exp_lat, exp_req, cyc, req_n, wait_n;
        legal = ref_legal(rd, wr, f3, a);
        if (!legal) begin
            ok = 0; exp_lat = 1; exp_req = 0;
        end else begin
            if (wr) ok = (1 + g <= TO);
            else    ok = (1 + g <= TO) && (2 + g + r <= TO);
            exp_lat = !ok ? 1 + TO : (wr ? 2 + g : 3 + g + r);
            exp_req = (1 + g <= TO) ? g + 1 : TO;
            if (rd && ok) exp_ld = ref_load(f3, a, rdat);
        end
        ex_valid = 1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        cyc = 0; req_n = 0; wait_n = 0; granted = 0; seen = 0;
        while (cyc < 40 && !seen) begin
            @(negedge clk);
            bus_gnt = 0; bus_rvalid = 0; bus_rdata = $urandom;
            if (cyc == 0) check_eq({tag, " stall_c0"}, stall, 1);
            if (done) begin
                seen = 1;
                check_eq({tag, " latency"}, cyc, exp_lat);
                check_eq({tag, " err"}, lsu_err, !ok);
                check_eq({tag, " load_data"}, load_data, exp_ld);
                check_eq({tag, " stall_done"}, stall, 0);
                check_eq({tag, " req_cycles"}, req_n, exp_req);
            end else if (bus_req) begin
                if (req_n == 0) begin
                    check_eq({tag, " bus_addr"}, bus_addr, a & 32'hffff_fffc);
                    check_eq({tag, " bus_we"}, bus_we, wr);
                    check_eq({tag, " bus_be"}, bus_be, ref_be(f3, a));
                    if (wr) check_eq({tag, " bus_wdata"}, bus_wdata, ref_wdata(f3, wd));
                end
                if (req_n == g) begin bus_gnt = 1; granted = 1; end
                req_n++;
            end else if (granted) begin
                check_eq({tag, " stall_wait"}, stall, 1);
                if (wait_n == r) begin bus_rvalid = 1; bus_rdata = rdat; end
                wait_n++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check_eq({tag, " done_seen"}, seen, 1);
        ex_valid = 0; mem_read = 0; mem_write = 0;
    endtask

    // One bubble cycle with stray bus handshakes that must be ignored.
    task automatic idle_cycle(input string tag);
        @(negedge clk);
        check_eq({tag, " idle_req"}, bus_req, 0);
        check_eq({tag, " idle_stall"}, stall, 0);
        check_eq({tag, " idle_done"}, done, 0);
        bus_gnt = $urandom; bus_rvalid = $urandom; bus_rdata = $urandom;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1; ex_valid = 0; mem_read = 0; mem_write = 0; funct3 = 0; addr = 0; wdata = 0;
        bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst stall", stall, 0);
        check_eq("rst done", done, 0);
        check_eq("rst err", lsu_err, 0);
        check_eq("rst load_data", load_data, 0);
        check_eq("rst bus_req", bus_req, 0);
        check_eq("rst bus_be", bus_be, 0);
        check_eq("rst bus_addr", bus_addr, 0);
        @(posedge clk); #1;
        rst = 0;

        run_op("sw", 0, 1, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, 0, 0);        idle_cycle("sw");
        run_op("lb", 1, 0, 3'b000, 32'h203, 0, 0, 0, 32'h80FF_FF7F);         idle_cycle("lb");
        check_eq("lb value", load_data, 32'hFFFF_FF80);
        run_op("lbu", 1, 0, 3'b100, 32'h203, 0, 0, 0, 32'h80FF_FF7F);        idle_cycle("lbu");
        check_eq("lbu value", load_data, 32'h0000_0080);
        run_op("lw_mis", 1, 0, 3'b010, 32'h102, 0, 0, 0, 0);                 idle_cycle("lw_mis");
        run_op("lh_mis", 1, 0, 3'b001, 32'h101, 0, 0, 0, 0);                 idle_cycle("lh_mis");
        run_op("ld_f3_011", 1, 0, 3'b011, 32'h100, 0, 0, 0, 0);              idle_cycle("ld_f3");
        run_op("st_f3_100", 0, 1, 3'b100, 32'h100, 0, 0, 0, 0);              idle_cycle("st_f3");
        run_op("rd_and_wr", 1, 1, 3'b010, 32'h100, 0, 0, 0, 0);              idle_cycle("rdwr");
        run_op("lw_tmo", 1, 0, 3'b010, 32'h80, 0, 99, 0, 0);                 idle_cycle("lw_tmo");
        run_op("lw_wait_tmo", 1, 0, 3'b010, 32'h80, 0, 1, 99, 0);            idle_cycle("lw_wtmo");
        run_op("sb", 0, 1, 3'b000, 32'h3, 32'h1234_5678, 1, 0, 0);           idle_cycle("sb");
        run_op("sh", 0, 1, 3'b001, 32'h2, 32'h1234_5678, 2, 0, 0);           idle_cycle("sh");
        run_op("lh", 1, 0, 3'b001, 32'h102, 0, 0, 1, 32'h8001_7FFF);         idle_cycle("lh");
        check_eq("lh value", load_data, 32'hFFFF_8001);

        for (int i = 0; i < 60; i++) begin
            int          kind = $urandom_range(0, 9);
            bit          rd   = (kind < 5) || (kind == 9);
            bit          wr   = (kind >= 5);
            logic [2:0]  f3   = $urandom_range(0, 7);
            logic [31:0] a    = $urandom;
            run_op("rand", rd, wr, f3, a, $urandom, $urandom_range(0, 4), $urandom_range(0, 3),
                   $urandom);
            idle_cycle("rand");
        end

        // Reset while a load sits in WAIT.
        run_op("lw_pre", 1, 0, 3'b010, 32'h40, 0, 0, 0, 32'hCAFE_F00D);      idle_cycle("lw_pre");
        ex_valid = 1; mem_read = 1; funct3 = 3'b010; addr = 32'h44;
        @(posedge clk); #1;
        @(negedge clk); bus_gnt = 1;
        @(posedge clk); #1;
        @(negedge clk);
        bus_gnt = 0;
        check_eq("rstw in_wait", stall & ~bus_req, 1);
        rst = 1;
        @(posedge clk); #1;
        rst = 0; ex_valid = 0; mem_read = 0;
        exp_ld = '0;
        @(negedge clk);
        check_eq("rstw bus_req", bus_req, 0);
        check_eq("rstw stall", stall, 0);
        check_eq("rstw done", done, 0);
        check_eq("rstw load_data", load_data, 0);
        check_eq("rstw bus_we", bus_we, 0);
        check_eq("rstw bus_be", bus_be, 0);
        bus_rvalid = 1; bus_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        @(negedge clk);
        bus_rvalid = 0;
        check_eq("rstw late_rvalid_done", done, 0);
        check_eq("rstw late_rvalid_data", load_data, 0);
        @(posedge clk); #1;
        run_op("post_rst", 1, 0, 3'b101, 32'h22, 0, 0, 0, 32'h9ABC_1234);    idle_cycle("post");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
